// File: rtl/multi_voice_synth.sv
// multi_voice_synth
//   Plays up to NUM_VOICES square-wave voices in parallel from an external
//   registered sequence ROM. Each voice has its own pitch and a 2-bit volume.
//   The voices are summed into a level word, and a first-order sigma-delta
//   modulator turns that level into a 1-bit stream for the audio pin.
//
// Parameters
//   NUM_VOICES  voice count (1..4)
//   STEP_BITS   one sequence step lasts 2^STEP_BITS clk cycles (2..30)
//   ADDR_BITS   the sequence is 2^ADDR_BITS steps long
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           global run enable; 0 freezes every register
//   start        one-cycle pulse; (re)starts playback at step 0
//   stop         one-cycle pulse; returns to idle and silences all voices
//   loop_en      1: wrap after the last step, 0: one-shot
//   seq_addr     sequence ROM address
//   seq_data     ROM data, one byte per voice, valid 1 cycle after seq_addr
//   busy         high whenever the sequencer is not idle
//   voice_out    raw square wave of each voice
//   audio_level  registered mix of the sounding voices
//   audio_pdm    sigma-delta bitstream
module multi_voice_synth #(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned STEP_BITS  = 22,
  parameter int unsigned ADDR_BITS  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  loop_en,
  output logic [ADDR_BITS-1:0]                  seq_addr,
  input  logic [8*NUM_VOICES-1:0]               seq_data,
  output logic                                  busy,
  output logic [NUM_VOICES-1:0]                 voice_out,
  output logic [$clog2(4*NUM_VOICES+1)-1:0]     audio_level,
  output logic                                  audio_pdm
);

  localparam int unsigned LVL_W = $clog2(4*NUM_VOICES+1);
  localparam int unsigned ACC_W = $clog2(8*NUM_VOICES);
  localparam int unsigned FS    = 4*NUM_VOICES;
  // PLAY lasts 2^STEP_BITS-2 cycles; the timer counts 0 .. 2^STEP_BITS-3.
  localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'((2**STEP_BITS) - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_e;

  // Divider reload: semitone period minus one.
  function automatic logic [8:0] div_reload(input logic [5:0] code);
    logic [5:0] k;
    logic [3:0] s;
    k = (code == 6'd0) ? 6'd0 : code - 6'd1;
    s = 4'(k % 6'd12);
    case (s)
      4'd0:    return 9'd511;
      4'd1:    return 9'd480;
      4'd2:    return 9'd455;
      4'd3:    return 9'd430;
      4'd4:    return 9'd405;
      4'd5:    return 9'd383;
      4'd6:    return 9'd361;
      4'd7:    return 9'd341;
      4'd8:    return 9'd322;
      4'd9:    return 9'd303;
      4'd10:   return 9'd286;
      default: return 9'd270;
    endcase
  endfunction

  // Octave prescaler reload: (256 >> octave) - 1 == 255 >> octave.
  function automatic logic [7:0] pre_reload(input logic [5:0] code);
    logic [5:0] k;
    logic [2:0] o;
    k = (code == 6'd0) ? 6'd0 : code - 6'd1;
    o = 3'(k / 6'd12);
    return 8'hFF >> o;
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [STEP_BITS-1:0]   timer_q, timer_d;
  logic                   play_end;

  logic                   voice_run;
  logic                   voice_load;
  logic                   voice_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      timer_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    timer_d  = '0;
    play_end = (state_q == S_PLAY) && (timer_q == STEP_LAST);
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else if (start) begin
      state_d = S_FETCH;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_FETCH: state_d = S_LOAD;
        S_LOAD:  state_d = S_PLAY;
        S_PLAY: begin
          if (play_end) begin
            // The last address wraps to 0, which is also the idle address.
            addr_d  = addr_q + ADDR_BITS'(1);
            state_d = ((addr_q == '1) && !loop_en) ? S_IDLE : S_FETCH;
          end else begin
            state_d = S_PLAY;
            timer_d = timer_q + STEP_BITS'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    seq_addr    = addr_q;
    voice_run   = (state_q != S_IDLE);
    voice_load  = (state_q == S_LOAD);
    // Voices fall silent on stop, on start and on every entry to idle.
    voice_clear = stop || start || (state_d == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Voices
  // ---------------------------------------------------------------------------
  logic [NUM_VOICES-1:0][5:0] code_q, code_d;
  logic [NUM_VOICES-1:0][1:0] vol_q,  vol_d;
  logic [NUM_VOICES-1:0][8:0] div_q,  div_d;
  logic [NUM_VOICES-1:0][7:0] pre_q,  pre_d;
  logic [NUM_VOICES-1:0]      out_q,  out_d;

  always_comb begin
    code_d = code_q;
    vol_d  = vol_q;
    div_d  = div_q;
    pre_d  = pre_q;
    out_d  = out_q;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (voice_clear) begin
        code_d[v] = '0;
        vol_d[v]  = '0;
        div_d[v]  = div_reload(6'd0);
        pre_d[v]  = pre_reload(6'd0);
        out_d[v]  = 1'b0;
      end else if (voice_load && (seq_data[8*v +: 6] != code_q[v])) begin
        // New note (or rest): restart from reload with the output low.
        code_d[v] = seq_data[8*v +: 6];
        vol_d[v]  = seq_data[8*v+6 +: 2];
        div_d[v]  = div_reload(seq_data[8*v +: 6]);
        pre_d[v]  = pre_reload(seq_data[8*v +: 6]);
        out_d[v]  = 1'b0;
      end else begin
        // Legato: same code keeps its phase, only the volume changes.
        if (voice_load) begin
          vol_d[v] = seq_data[8*v+6 +: 2];
        end
        if (voice_run && (code_q[v] != '0)) begin
          if (div_q[v] == '0) begin
            div_d[v] = div_reload(code_q[v]);
            if (pre_q[v] == '0) begin
              pre_d[v] = pre_reload(code_q[v]);
              out_d[v] = ~out_q[v];
            end else begin
              pre_d[v] = pre_q[v] - 8'd1;
            end
          end else begin
            div_d[v] = div_q[v] - 9'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        code_q[v] <= '0;
        vol_q[v]  <= '0;
        div_q[v]  <= div_reload(6'd0);
        pre_q[v]  <= pre_reload(6'd0);
        out_q[v]  <= 1'b0;
      end
    end else if (en) begin
      code_q <= code_d;
      vol_q  <= vol_d;
      div_q  <= div_d;
      pre_q  <= pre_d;
      out_q  <= out_d;
    end
  end

  assign voice_out = out_q;

  // ---------------------------------------------------------------------------
  // Mixer and sigma-delta modulator
  // ---------------------------------------------------------------------------
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_n;
  logic             pdm_q, pdm_d;

  always_comb begin
    lvl_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (out_q[v]) begin
        lvl_d = lvl_d + LVL_W'(vol_q[v]) + LVL_W'(1);
      end
    end
  end

  always_comb begin
    acc_n = acc_q + ACC_W'(lvl_q);
    if (acc_n >= ACC_W'(FS)) begin
      pdm_d = 1'b1;
      acc_d = acc_n - ACC_W'(FS);
    end else begin
      pdm_d = 1'b0;
      acc_d = acc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q <= '0;
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else if (en) begin
      lvl_q <= lvl_d;
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign audio_level = lvl_q;
  assign audio_pdm   = pdm_q;

endmodule

// File: tb/tb_multi_voice_synth.sv
// Testbench for multi_voice_synth. A reference model advances one clock edge
// at a time from the playback rules (step position, note start time, ideal
// half-period) and pushes the expected outputs into a queue; a monitor pops
// one entry per clock and compares it with the DUT outputs.
module tb_multi_voice_synth;

  localparam int N      = 2;
  localparam int SB     = 12;
  localparam int AB     = 2;
  localparam int STEP   = 1 << SB;
  localparam int NSTEPS = 1 << AB;
  localparam int FS     = 4 * N;
  localparam int WL     = $clog2(4*N+1);

  typedef struct packed {
    logic          busy;
    logic [AB-1:0] addr;
    logic [N-1:0]  vout;
    logic [WL-1:0] lvl;
    logic          pdm;
  } obs_t;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [AB-1:0]     seq_addr;
  logic [8*N-1:0]    seq_data;
  logic              busy;
  logic [N-1:0]      voice_out;
  logic [WL-1:0]     audio_level;
  logic              audio_pdm;

  multi_voice_synth #(
    .NUM_VOICES (N),
    .STEP_BITS  (SB),
    .ADDR_BITS  (AB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .seq_addr    (seq_addr),
    .seq_data    (seq_data),
    .busy        (busy),
    .voice_out   (voice_out),
    .audio_level (audio_level),
    .audio_pdm   (audio_pdm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered sequence ROM.
  logic [8*N-1:0] rom [NSTEPS];
  always @(posedge clk) seq_data <= rom[seq_addr];

  int TBL [12] = '{512, 481, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};

  function automatic int half(input int c);
    int k;
    k = c - 1;
    return TBL[k % 12] * (256 >> (k / 12));
  endfunction

  // ---------------- reference model ----------------
  bit m_play;
  int m_pos;
  int m_code [N];
  int m_vol  [N];
  int m_t0   [N];
  bit m_out  [N];
  int m_lvl;
  int m_acc;
  bit m_pdm;

  obs_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic m_clear();
    for (int v = 0; v < N; v++) begin
      m_code[v] = 0;
      m_vol[v]  = 0;
    end
  endtask

  task automatic model_edge();
    int lvl_n;
    int accn;
    logic [8*N-1:0] w;
    if (!rst_n) begin
      m_play = 0; m_pos = 0; m_lvl = 0; m_acc = 0; m_pdm = 0;
      m_clear();
      for (int v = 0; v < N; v++) begin
        m_out[v] = 0;
        m_t0[v]  = 0;
      end
      return;
    end
    if (!en) return;
    lvl_n = 0;
    for (int v = 0; v < N; v++) if (m_out[v]) lvl_n += m_vol[v] + 1;
    accn = m_acc + m_lvl;
    if (accn >= FS) begin m_pdm = 1; m_acc = accn - FS; end
    else begin m_pdm = 0; m_acc = accn; end
    m_lvl = lvl_n;
    if (stop) begin
      m_play = 0;
      m_clear();
    end else if (start) begin
      m_play = 1;
      m_pos  = 0;
      m_clear();
    end else if (m_play) begin
      if (m_pos % STEP == 1) begin
        w = rom[(m_pos / STEP) % NSTEPS];
        for (int v = 0; v < N; v++) begin
          int c;
          c = int'(w[8*v +: 6]);
          m_vol[v] = int'(w[8*v+6 +: 2]);
          if (c != m_code[v]) begin
            m_code[v] = c;
            m_t0[v]   = m_pos + 1;
          end
        end
      end
      m_pos++;
      if ((m_pos % STEP == 0) && ((m_pos / STEP) % NSTEPS == 0) && !loop_en) begin
        m_play = 0;
        m_clear();
      end
    end
    for (int v = 0; v < N; v++) begin
      if (m_play && m_code[v] != 0)
        m_out[v] = (((m_pos - m_t0[v]) / half(m_code[v])) % 2) == 1;
      else
        m_out[v] = 0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.busy = m_play;
    o.addr = m_play ? AB'((m_pos / STEP) % NSTEPS) : '0;
    for (int v = 0; v < N; v++) o.vout[v] = m_out[v];
    o.lvl = WL'(m_lvl);
    o.pdm = m_pdm;
    return o;
  endfunction

  // One clock: drive inputs away from the edge, predict, then wait the edge.
  task automatic cycle(input bit r, input bit e, input bit st, input bit sp, input bit lp);
    @(negedge clk);
    rst_n = r; en = e; start = st; stop = sp; loop_en = lp;
    model_edge();
    exp_q.push_back(model_obs());
    @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.busy = busy; a.addr = seq_addr; a.vout = voice_out;
      a.lvl = audio_level; a.pdm = audio_pdm;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d busy/addr/vout/lvl/pdm got %0b/%0d/%b/%0d/%0b want %0b/%0d/%b/%0d/%0b",
                 cyc, a.busy, a.addr, a.vout, a.lvl, a.pdm, e.busy, e.addr, e.vout, e.lvl, e.pdm);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] vb(input int vol, input int code);
    return {2'(vol), 6'(code)};
  endfunction

  task automatic random_rom();
    int prev [N];
    for (int s = 0; s < NSTEPS; s++) begin
      for (int v = 0; v < N; v++) begin
        int r;
        int c;
        r = int'($urandom_range(0, 9));
        if (r < 2) c = 0;
        else if (r < 5 && s > 0) c = prev[v];
        else c = int'($urandom_range(53, 63));
        prev[v] = c;
        rom[s][8*v +: 8] = vb(int'($urandom_range(0, 3)), c);
      end
    end
  endtask

  task automatic random_run(input int len, input bit lp);
    int pause_at;
    int restart_at;
    random_rom();
    pause_at   = int'($urandom_range(200, 3000));
    restart_at = int'($urandom_range(4000, 6000));
    cycle(1, 1, 1, 0, lp);
    for (int i = 0; i < len; i++) begin
      if (i == pause_at) begin
        repeat (100) cycle(1, 0, 0, 0, lp);
        cycle(1, 0, 1, 1, lp);
      end else if (i == restart_at) begin
        cycle(1, 1, 1, 0, lp);
      end else begin
        cycle(1, ($urandom_range(0, 63) != 0), 0, 0, lp);
      end
    end
    cycle(1, 1, 0, 1, lp);
    cycle(1, 1, 0, 0, lp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    for (int s = 0; s < NSTEPS; s++) rom[s] = '0;
    repeat (3) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);

    // Directed one-shot: legato across step 1, note change at step 2,
    // vol 1 + vol 0 mix in step 1, and a 100-cycle pause in step 0.
    rom[0] = {vb(0, 61), vb(3, 63)};
    rom[1] = {vb(0, 61), vb(1, 63)};
    rom[2] = {vb(2, 0),  vb(2, 62)};
    rom[3] = {vb(2, 57), vb(3, 0)};
    cycle(1, 1, 1, 0, 0);
    for (int i = 0; i < 4*STEP + 20; i++)
      cycle(1, !(i >= 1000 && i < 1100), 0, 0, 0);

    // Randomised runs: looping across the wrap, then one-shot/looping mixes.
    random_run(18000, 1'b1);
    random_run(7000, 1'(int'($urandom_range(0, 1))));
    random_run(7000, 1'b0);

    // start and stop together: stop wins.
    cycle(1, 1, 1, 0, 0);
    repeat (5) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0);
    repeat (3) cycle(1, 1, 0, 0, 0);

    // Reset in the middle of playback.
    random_rom();
    cycle(1, 1, 1, 0, 1);
    repeat (500) cycle(1, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(1, 1, 0, 0, 1);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
